// File: rtl/fir_out_sat_fifo_if.sv
// Stream bundle around the FIR output conditioner.
// The sample input has no ready signal. The output is AXI-Stream style with tready and tlast.
interface fir_out_sat_fifo_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic                    s_tvalid;
    logic signed [IN_W-1:0]  s_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic signed [OUT_W-1:0] m_tdata;
    logic                    m_tlast;

    modport master (
        input  s_tvalid, s_tdata, m_tready,
        output m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        output s_tvalid, s_tdata, m_tready,
        input  m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/fir_out_sat_fifo.sv
// Rounds, shifts and saturates FIR samples, then queues them in a show-ahead FIFO.
// The FIFO drives a framed output stream and keeps sticky saturation and drop statistics.
module fir_out_sat_fifo #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 0,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    fir_out_sat_fifo_if.master         bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clr_status,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                sat_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

    logic signed [IN_W:0]    s_ext;
    logic signed [IN_W:0]    s_rnd;
    logic                    sat_hi, sat_lo, sat_ev;
    logic signed [OUT_W-1:0] s_sat;

    assign s_ext = {bus.s_tdata[IN_W-1], bus.s_tdata};

    // One extra bit of headroom keeps the rounding add from wrapping at full scale.
    generate
        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
            logic signed [IN_W:0] sum;
            assign sum   = s_ext + HALF;
            assign s_rnd = sum >>> SHIFT;
        end else begin : g_nornd
            assign s_rnd = s_ext;
        end
    endgenerate

    assign sat_hi = s_rnd > MAX_V;
    assign sat_lo = s_rnd < MIN_V;
    assign sat_ev = bus.s_tvalid && (sat_hi || sat_lo);
    assign s_sat  = sat_hi ? MAX_V[OUT_W-1:0] :
                    sat_lo ? MIN_V[OUT_W-1:0] : s_rnd[OUT_W-1:0];

    logic                    stg_vld;
    logic signed [OUT_W-1:0] stg_data;
    logic [OUT_W-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [FC_W-1:0]         frame_cnt;
    logic                    not_empty, full, pop, push, drop;

    assign not_empty = level != '0;
    assign full      = level == LW'(DEPTH);
    assign pop       = not_empty && bus.m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign push      = stg_vld && (!full || pop);
    assign drop      = stg_vld && !push;

    assign bus.m_tvalid = not_empty;
    assign bus.m_tdata  = not_empty ? mem[rd_ptr] : '0;
    assign bus.m_tlast  = not_empty && (frame_cnt == FC_W'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= stg_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld   <= 1'b0;
            stg_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_cnt <= '0;
        end else begin
            stg_vld <= bus.s_tvalid;
            if (bus.s_tvalid) stg_data <= s_sat;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop) begin
                if (frame_cnt == FC_W'(FRAME_LEN - 1)) frame_cnt <= '0;
                else                                   frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // A clear that coincides with a new event leaves that event counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            sat_cnt  <= '0;
        end else if (clr_status) begin
            overflow <= drop;
            drop_cnt <= {15'd0, drop};
            sat_cnt  <= {15'd0, sat_ev};
        end else begin
            if (drop) overflow <= 1'b1;
            if (drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
            if (sat_ev && sat_cnt != 16'hFFFF) sat_cnt  <= sat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fir_out_sat_fifo.sv
// Directed bench for fir_out_sat_fifo.
// dut0 runs with SHIFT=0 and dut2 with SHIFT=2; both use DEPTH=16 and FRAME_LEN=8.
module tb_fir_out_sat_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr0, clr2;
    logic [4:0]  level0, level2;
    logic        ovf0, ovf2;
    logic [15:0] drop0, sat0, drop2, sat2;
    int          vecs = 0;
    int          errs = 0;

    fir_out_sat_fifo_if #(.IN_W(32), .OUT_W(16)) bus0 ();
    fir_out_sat_fifo_if #(.IN_W(32), .OUT_W(16)) bus2 ();

    fir_out_sat_fifo #(.IN_W(32), .OUT_W(16), .SHIFT(0), .DEPTH(16), .FRAME_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .level(level0), .overflow(ovf0),
        .clr_status(clr0), .drop_cnt(drop0), .sat_cnt(sat0)
    );

    fir_out_sat_fifo #(.IN_W(32), .OUT_W(16), .SHIFT(2), .DEPTH(16), .FRAME_LEN(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .level(level2), .overflow(ovf2),
        .clr_status(clr2), .drop_cnt(drop2), .sat_cnt(sat2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        vecs++; if (bus0.m_tvalid !== 1'b0) begin errs++; $display("FAIL reset_tvalid got %b exp 0", bus0.m_tvalid); end
        vecs++; if (bus0.m_tdata !== 16'sd0) begin errs++; $display("FAIL reset_tdata got %0d exp 0", bus0.m_tdata); end
        vecs++; if (bus0.m_tlast !== 1'b0) begin errs++; $display("FAIL reset_tlast got %b exp 0", bus0.m_tlast); end
        vecs++; if (level0 !== 5'd0) begin errs++; $display("FAIL reset_level got %0d exp 0", level0); end
        vecs++; if ({ovf0, drop0, sat0} !== 33'd0) begin errs++; $display("FAIL reset_status got %b/%0d/%0d exp 0/0/0", ovf0, drop0, sat0); end
        vecs++; if (bus2.m_tvalid !== 1'b0) begin errs++; $display("FAIL reset_tvalid2 got %b exp 0", bus2.m_tvalid); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sat();
        int din[4] = '{100, 40000, -40000, -5};
        logic signed [15:0] dexp[4] = '{16'sd100, 16'sd32767, -16'sd32768, -16'sd5};
        bus0.m_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                bus0.s_tvalid = 1'b1; bus0.s_tdata = din[k];
            end else begin
                bus0.s_tvalid = 1'b0; bus0.s_tdata = 32'sd70000;
            end
            tick();
            vecs++; if (bus0.m_tvalid !== (k >= 1 && k <= 4)) begin errs++; $display("FAIL sat_tvalid[%0d] got %b exp %b", k, bus0.m_tvalid, (k >= 1 && k <= 4)); end
            if (k >= 1 && k <= 4) begin
                vecs++; if (bus0.m_tdata !== dexp[k-1]) begin errs++; $display("FAIL sat_tdata[%0d] got %0d exp %0d", k, bus0.m_tdata, dexp[k-1]); end
            end
        end
        vecs++; if (sat0 !== 16'd2) begin errs++; $display("FAIL sat_cnt got %0d exp 2", sat0); end
        vecs++; if (drop0 !== 16'd0) begin errs++; $display("FAIL sat_drop got %0d exp 0", drop0); end
    endtask

    task automatic test_round();
        int din[5] = '{6, -6, 5, 131069, 131070};
        logic signed [15:0] dexp[5] = '{16'sd2, -16'sd1, 16'sd1, 16'sd32767, 16'sd32767};
        bus2.m_tready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                bus2.s_tvalid = 1'b1; bus2.s_tdata = din[k];
            end else begin
                bus2.s_tvalid = 1'b0; bus2.s_tdata = 32'sd0;
            end
            tick();
            vecs++; if (bus2.m_tvalid !== (k >= 1 && k <= 5)) begin errs++; $display("FAIL rnd_tvalid[%0d] got %b exp %b", k, bus2.m_tvalid, (k >= 1 && k <= 5)); end
            if (k >= 1 && k <= 5) begin
                vecs++; if (bus2.m_tdata !== dexp[k-1]) begin errs++; $display("FAIL rnd_tdata[%0d] got %0d exp %0d", k, bus2.m_tdata, dexp[k-1]); end
            end
        end
        // 131069 rounds to exactly 32767; only 131070 exceeds the range
        vecs++; if (sat2 !== 16'd1) begin errs++; $display("FAIL rnd_sat_cnt got %0d exp 1", sat2); end
    endtask

    task automatic test_overflow();
        logic el;
        bus0.m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus0.s_tvalid = 1'b1; bus0.s_tdata = i + 1;
            tick();
        end
        bus0.s_tvalid = 1'b0;
        repeat (2) tick();
        vecs++; if (level0 !== 5'd16) begin errs++; $display("FAIL ovf_level got %0d exp 16", level0); end
        vecs++; if (drop0 !== 16'd4) begin errs++; $display("FAIL ovf_drop got %0d exp 4", drop0); end
        vecs++; if (ovf0 !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b exp 1", ovf0); end
        bus0.m_tready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            el = ((4 + j) % 8 == 0);
            vecs++; if (bus0.m_tvalid !== 1'b1 || bus0.m_tdata !== 16'(j)) begin errs++; $display("FAIL ovf_drain[%0d] got v=%b d=%0d exp v=1 d=%0d", j, bus0.m_tvalid, bus0.m_tdata, j); end
            vecs++; if (bus0.m_tlast !== el) begin errs++; $display("FAIL ovf_tlast[%0d] got %b exp %b", j, bus0.m_tlast, el); end
            tick();
        end
        vecs++; if (bus0.m_tvalid !== 1'b0 || level0 !== 5'd0 || bus0.m_tdata !== 16'sd0) begin errs++; $display("FAIL ovf_empty got v=%b lvl=%0d d=%0d exp 0/0/0", bus0.m_tvalid, level0, bus0.m_tdata); end
    endtask

    task automatic test_full_stream();
        int n = 0;
        logic signed [15:0] e;
        bus0.m_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus0.s_tvalid = 1'b1; bus0.s_tdata = (i < 16) ? 101 + i : 201;
            tick();
        end
        vecs++; if (level0 !== 5'd16) begin errs++; $display("FAIL full_level got %0d exp 16", level0); end
        bus0.m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus0.s_tdata = 202 + i;
            tick();
            vecs++; if (level0 !== 5'd16 || drop0 !== 16'd4) begin errs++; $display("FAIL full_pass[%0d] got lvl=%0d drop=%0d exp 16/4", i, level0, drop0); end
            vecs++; if (bus0.m_tdata !== 16'(102 + i)) begin errs++; $display("FAIL full_head[%0d] got %0d exp %0d", i, bus0.m_tdata, 102 + i); end
        end
        bus0.s_tvalid = 1'b0;
        for (int c = 0; c < 40 && n < 17; c++) begin
            if (bus0.m_tvalid) begin
                e = (n < 8) ? 16'(109 + n) : 16'(193 + n);
                vecs++; if (bus0.m_tdata !== e) begin errs++; $display("FAIL full_drain[%0d] got %0d exp %0d", n, bus0.m_tdata, e); end
                n++;
            end
            tick();
        end
        vecs++; if (n != 17 || bus0.m_tvalid !== 1'b0) begin errs++; $display("FAIL full_drain_count got %0d v=%b exp 17 v=0", n, bus0.m_tvalid); end
        vecs++; if (drop0 !== 16'd4) begin errs++; $display("FAIL full_drop got %0d exp 4", drop0); end
    endtask

    task automatic test_clear();
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        vecs++; if ({ovf0, drop0, sat0} !== 33'd0) begin errs++; $display("FAIL clr_status got %b/%0d/%0d exp 0/0/0", ovf0, drop0, sat0); end
        bus0.s_tvalid = 1'b1; bus0.s_tdata = 40000;
        tick();
        vecs++; if (sat0 !== 16'd1) begin errs++; $display("FAIL clr_sat_inc got %0d exp 1", sat0); end
        bus0.s_tdata = 50000; clr0 = 1'b1;
        tick();
        clr0 = 1'b0; bus0.s_tvalid = 1'b0;
        vecs++; if (sat0 !== 16'd1) begin errs++; $display("FAIL clr_coincide got %0d exp 1", sat0); end
        repeat (4) tick();
        vecs++; if (sat0 !== 16'd1 || bus0.m_tvalid !== 1'b0) begin errs++; $display("FAIL clr_settle got sat=%0d v=%b exp 1/0", sat0, bus0.m_tvalid); end
    endtask

    task automatic test_tlast();
        int n = 0;
        int lasts = 0;
        logic v, l, el;
        logic signed [15:0] d;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int c = 0; c < 200 && n < 24; c++) begin
            bus0.m_tready = (c % 2 == 0);
            if (c < 24) begin
                bus0.s_tvalid = 1'b1; bus0.s_tdata = 301 + c;
            end else begin
                bus0.s_tvalid = 1'b0;
            end
            v = bus0.m_tvalid; d = bus0.m_tdata; l = bus0.m_tlast;
            if (v && bus0.m_tready) begin
                el = (n % 8 == 7);
                vecs++; if (d !== 16'(301 + n)) begin errs++; $display("FAIL tl_data[%0d] got %0d exp %0d", n, d, 301 + n); end
                vecs++; if (l !== el) begin errs++; $display("FAIL tl_last[%0d] got %b exp %b", n, l, el); end
                if (l) lasts++;
                n++;
                tick();
            end else if (v) begin
                tick();
                vecs++; if (bus0.m_tvalid !== 1'b1 || bus0.m_tdata !== d) begin errs++; $display("FAIL tl_hold got v=%b d=%0d exp v=1 d=%0d", bus0.m_tvalid, bus0.m_tdata, d); end
            end else begin
                tick();
            end
        end
        vecs++; if (n != 24 || lasts != 3) begin errs++; $display("FAIL tl_count got words=%0d lasts=%0d exp 24/3", n, lasts); end
        vecs++; if (drop0 !== 16'd0) begin errs++; $display("FAIL tl_drop got %0d exp 0", drop0); end
    endtask

    task automatic test_reset_mid();
        logic el;
        bus0.m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus0.s_tvalid = 1'b1; bus0.s_tdata = 501 + i;
            tick();
        end
        bus0.s_tvalid = 1'b0;
        repeat (2) tick();
        vecs++; if (level0 !== 5'd5) begin errs++; $display("FAIL mid_level got %0d exp 5", level0); end
        #2;
        rst = 1'b1;
        #1;
        vecs++; if (bus0.m_tvalid !== 1'b0 || bus0.m_tdata !== 16'sd0 || bus0.m_tlast !== 1'b0 || level0 !== 5'd0) begin errs++; $display("FAIL mid_async got v=%b d=%0d l=%b lvl=%0d exp 0/0/0/0", bus0.m_tvalid, bus0.m_tdata, bus0.m_tlast, level0); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus0.s_tvalid = 1'b1; bus0.s_tdata = 701 + i;
            tick();
        end
        bus0.s_tvalid = 1'b0;
        repeat (2) tick();
        vecs++; if (level0 !== 5'd8) begin errs++; $display("FAIL mid_refill got %0d exp 8", level0); end
        bus0.m_tready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            el = (j == 7);
            vecs++; if (bus0.m_tdata !== 16'(701 + j) || bus0.m_tlast !== el) begin errs++; $display("FAIL mid_word[%0d] got d=%0d l=%b exp d=%0d l=%b", j, bus0.m_tdata, bus0.m_tlast, 701 + j, el); end
            tick();
        end
        vecs++; if (bus0.m_tvalid !== 1'b0) begin errs++; $display("FAIL mid_end got v=%b exp 0", bus0.m_tvalid); end
    endtask

    initial begin
        bus0.s_tvalid = 1'b0; bus0.s_tdata = '0; bus0.m_tready = 1'b0;
        bus2.s_tvalid = 1'b0; bus2.s_tdata = '0; bus2.m_tready = 1'b0;
        clr0 = 1'b0; clr2 = 1'b0;
        test_reset();
        test_sat();
        test_round();
        test_overflow();
        test_full_stream();
        test_clear();
        test_tlast();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
